// File: rtl/hack_mmio_peripherals_if.sv
// hack_mmio_peripherals_if: Hack data-bus side of the MMIO peripheral block.
interface hack_mmio_peripherals_if #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDRESS_WIDTH = 15
);
    logic                     bus_strobe;
    logic [ADDRESS_WIDTH-1:0] bus_address;
    logic                     bus_write;
    logic [WORD_WIDTH-1:0]    bus_wdata;
    logic [WORD_WIDTH-1:0]    bus_rdata;
    logic                     bus_hit;
    modport master (output bus_strobe, bus_address, bus_write, bus_wdata, input bus_rdata, bus_hit);
    modport slave (input bus_strobe, bus_address, bus_write, bus_wdata, output bus_rdata, bus_hit);
endinterface

// File: rtl/hack_mmio_peripherals.sv
// hack_mmio_peripherals: register window with keyboard keycode FIFO and N GPIO channels
// (direction, synchronised inputs, sticky rising-edge flags) for the Hack SoC.
module hack_mmio_peripherals #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDRESS_WIDTH = 15,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = 'h6000,
    parameter int GPIO_CHANNELS = 2,
    parameter int GPIO_WIDTH = 8,
    parameter int KEY_FIFO_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    hack_mmio_peripherals_if.slave              bus,
    input  logic [7:0]                          keycode,
    input  logic [GPIO_CHANNELS*GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_CHANNELS*GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_CHANNELS*GPIO_WIDTH-1:0] gpio_oe,
    output logic                                irq
);
    localparam int PW = $clog2(KEY_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = GPIO_CHANNELS * GPIO_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] NREG = ADDRESS_WIDTH'(4 + 4 * GPIO_CHANNELS);

    logic [ADDRESS_WIDTH-1:0] off, grp;
    logic [1:0]               sel;
    logic                     hit, wr, rd;
    logic [7:0]               ksync1, ksync, kprev;
    logic [7:0]               kmem [KEY_FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;
    logic                     ovf, push, pop, full, push_ok;
    logic [GW-1:0]            gsync1, gsync, gprev, edge_q, edge_clr;

    // Offsets group into fours: group 0 is the keyboard, group c+1 is GPIO channel c.
    assign off = bus.bus_address - BASE_ADDRESS;
    assign grp = off >> 2;
    assign sel = off[1:0];
    assign hit = bus.bus_address >= BASE_ADDRESS && off < NREG;
    assign wr = bus.bus_strobe && bus.bus_write && hit;
    assign rd = bus.bus_strobe && !bus.bus_write && hit;
    assign bus.bus_hit = hit;
    assign full = count == CW'(KEY_FIFO_DEPTH);
    assign push = ksync != '0 && ksync != kprev;
    assign pop = rd && grp == '0 && sel == 2'd1 && count != '0;
    assign push_ok = push && (!full || pop);

    always_comb begin
        edge_clr = '0;
        for (int c = 0; c < GPIO_CHANNELS; c++)
            if (wr && grp == ADDRESS_WIDTH'(c + 1) && sel == 2'd3)
                edge_clr[c*GPIO_WIDTH +: GPIO_WIDTH] = bus.bus_wdata[GPIO_WIDTH-1:0];
    end

    always_comb begin
        bus.bus_rdata = '0;
        if (hit && grp == '0)
            bus.bus_rdata = sel == 2'd0 ? WORD_WIDTH'(ksync) :
                            sel == 2'd1 ? (count != '0 ? WORD_WIDTH'(kmem[rd_ptr]) : '0) :
                            sel == 2'd2 ? (WORD_WIDTH'(ovf) << 15) | WORD_WIDTH'(count) : '0;
        for (int c = 0; c < GPIO_CHANNELS; c++)
            if (hit && grp == ADDRESS_WIDTH'(c + 1))
                bus.bus_rdata = WORD_WIDTH'(sel == 2'd0 ? gsync[c*GPIO_WIDTH +: GPIO_WIDTH] :
                                            sel == 2'd1 ? gpio_o[c*GPIO_WIDTH +: GPIO_WIDTH] :
                                            sel == 2'd2 ? gpio_oe[c*GPIO_WIDTH +: GPIO_WIDTH] :
                                                          edge_q[c*GPIO_WIDTH +: GPIO_WIDTH]);
    end

    always_ff @(posedge clk)
        if (push_ok) kmem[wr_ptr] <= ksync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ksync1  <= '0;
            ksync   <= '0;
            kprev   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            gsync1  <= '0;
            gsync   <= '0;
            gprev   <= '0;
            edge_q  <= '0;
            gpio_o  <= '0;
            gpio_oe <= '0;
            irq     <= 1'b0;
        end else begin
            ksync1 <= keycode;
            ksync  <= ksync1;
            kprev  <= ksync;
            gsync1 <= gpio_i;
            gsync  <= gsync1;
            gprev  <= gsync;
            // A new rising edge beats a write-1-clear landing in the same cycle.
            edge_q <= (edge_q & ~edge_clr) | (gsync & ~gprev);
            irq    <= |edge_q || count != '0;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
            if (push && full && !pop) ovf <= 1'b1;
            else if (wr && grp == '0 && sel == 2'd2 && bus.bus_wdata[15]) ovf <= 1'b0;
            for (int c = 0; c < GPIO_CHANNELS; c++) begin
                if (wr && grp == ADDRESS_WIDTH'(c + 1) && sel == 2'd1)
                    gpio_o[c*GPIO_WIDTH +: GPIO_WIDTH] <= bus.bus_wdata[GPIO_WIDTH-1:0];
                if (wr && grp == ADDRESS_WIDTH'(c + 1) && sel == 2'd2)
                    gpio_oe[c*GPIO_WIDTH +: GPIO_WIDTH] <= bus.bus_wdata[GPIO_WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_hack_mmio_peripherals.sv
// tb_hack_mmio_peripherals: randomized bench for hack_mmio_peripherals against a
// queue/array reference model of the register map, keyboard FIFO and GPIO channels.
module tb_hack_mmio_peripherals;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  keycode = '0;
    logic [15:0] gpio_i = '0;
    logic [15:0] gpio_o, gpio_oe;
    logic        irq;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [7:0]  m_out [2];
    logic [7:0]  m_dir [2];
    logic [7:0]  kq [$];

    hack_mmio_peripherals_if bus_if ();

    hack_mmio_peripherals dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_if), .keycode(keycode),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        bus_if.bus_address = a;
        bus_if.bus_write = 1'b1;
        bus_if.bus_wdata = d;
        bus_if.bus_strobe = 1'b1;
        tick(1);
        bus_if.bus_strobe = 1'b0;
        bus_if.bus_write = 1'b0;
    endtask

    task automatic peek(input logic [14:0] a, output logic [15:0] d);
        bus_if.bus_address = a;
        bus_if.bus_write = 1'b0;
        bus_if.bus_strobe = 1'b0;
        #1;
        d = bus_if.bus_rdata;
    endtask

    task automatic pop(output logic [15:0] d);
        peek(15'h6001, d);
        bus_if.bus_strobe = 1'b1;
        tick(1);
        bus_if.bus_strobe = 1'b0;
    endtask

    task automatic press(input logic [7:0] code);
        keycode = code;
        tick(4);
        keycode = 8'h00;
        tick(2);
    endtask

    task automatic test_reset;
        logic [15:0] d;
        reset_n = 1'b0;
        keycode = 8'h41;
        repeat (2) begin
            gpio_i = 16'($urandom);
            tick(1);
        end
        tests_run++; if (gpio_o !== 16'h0) begin tests_failed++; $display("FAIL reset_gpio_o got=%h exp=0000", gpio_o); end
        tests_run++; if (gpio_oe !== 16'h0) begin tests_failed++; $display("FAIL reset_gpio_oe got=%h exp=0000", gpio_oe); end
        tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq got=%b exp=0", irq); end
        reset_n = 1'b1;
        gpio_i = '0;
        m_out = '{8'h0, 8'h0};
        m_dir = '{8'h0, 8'h0};
        tick(2);
        peek(15'h6002, d);
        tests_run++; if (d !== 16'h0000) begin tests_failed++; $display("FAIL reset_kstat_before_push got=%h exp=0000", d); end
        tick(1);
        peek(15'h6002, d);
        tests_run++; if (d !== 16'h0001) begin tests_failed++; $display("FAIL reset_kstat_after_push got=%h exp=0001", d); end
        keycode = 8'h00;
        pop(d);
        tests_run++; if (d !== 16'h0041) begin tests_failed++; $display("FAIL reset_first_key got=%h exp=0041", d); end
        tick(2);
    endtask

    task automatic test_hit;
        logic [15:0] d;
        peek(15'h5FFF, d);
        tests_run++; if (bus_if.bus_hit !== 1'b0 || d !== 16'h0) begin tests_failed++; $display("FAIL hit_below got=%b/%h exp=0/0000", bus_if.bus_hit, d); end
        peek(15'h6000, d);
        tests_run++; if (bus_if.bus_hit !== 1'b1) begin tests_failed++; $display("FAIL hit_base got=%b exp=1", bus_if.bus_hit); end
        peek(15'h600B, d);
        tests_run++; if (bus_if.bus_hit !== 1'b1) begin tests_failed++; $display("FAIL hit_last got=%b exp=1", bus_if.bus_hit); end
        peek(15'h600C, d);
        tests_run++; if (bus_if.bus_hit !== 1'b0 || d !== 16'h0) begin tests_failed++; $display("FAIL hit_above got=%b/%h exp=0/0000", bus_if.bus_hit, d); end
        peek(15'h6003, d);
        tests_run++; if (d !== 16'h0) begin tests_failed++; $display("FAIL reserved_read got=%h exp=0000", d); end
    endtask

    task automatic test_gpio_write;
        logic [15:0] d, r;
        int c, k;
        wr(15'h6009, 16'h12A5);
        m_out[1] = 8'hA5;
        tests_run++; if (gpio_o !== 16'hA500) begin tests_failed++; $display("FAIL gpio_out1 got=%h exp=A500", gpio_o); end
        peek(15'h6009, d);
        tests_run++; if (d !== 16'h00A5) begin tests_failed++; $display("FAIL gpio_out1_readback got=%h exp=00A5", d); end
        wr(15'h600A, 16'h00FF);
        m_dir[1] = 8'hFF;
        tests_run++; if (gpio_oe !== 16'hFF00) begin tests_failed++; $display("FAIL gpio_dir1 got=%h exp=FF00", gpio_oe); end
        for (int i = 0; i < 12; i++) begin
            c = $urandom_range(0, 1);
            k = $urandom_range(0, 1);
            d = 16'($urandom);
            wr(15'h6005 + 15'(4 * c + k), d);
            if (k == 1) m_dir[c] = d[7:0]; else m_out[c] = d[7:0];
            tests_run++; if (gpio_o !== {m_out[1], m_out[0]} || gpio_oe !== {m_dir[1], m_dir[0]}) begin
                tests_failed++; $display("FAIL gpio_rand_pins got=%h/%h exp=%h/%h", gpio_o, gpio_oe, {m_out[1], m_out[0]}, {m_dir[1], m_dir[0]});
            end
            peek(15'h6005 + 15'(4 * c + k), r);
            tests_run++; if (r !== {8'h0, d[7:0]}) begin tests_failed++; $display("FAIL gpio_rand_readback got=%h exp=%h", r, {8'h0, d[7:0]}); end
        end
        bus_if.bus_address = 15'h6005;
        bus_if.bus_wdata = ~{m_out[1], m_out[0]};
        bus_if.bus_write = 1'b1;
        tick(1);
        bus_if.bus_write = 1'b0;
        wr(15'h600D, 16'hFFFF);
        wr(15'h6000, 16'hFFFF);
        tests_run++; if (gpio_o !== {m_out[1], m_out[0]} || gpio_oe !== {m_dir[1], m_dir[0]}) begin
            tests_failed++; $display("FAIL gpio_no_effect got=%h/%h exp=%h/%h", gpio_o, gpio_oe, {m_out[1], m_out[0]}, {m_dir[1], m_dir[0]});
        end
        r = 16'($urandom);
        gpio_i = r;
        tick(2);
        peek(15'h6004, d);
        tests_run++; if (d !== {8'h0, r[7:0]}) begin tests_failed++; $display("FAIL gpio_in0 got=%h exp=%h", d, {8'h0, r[7:0]}); end
        peek(15'h6008, d);
        tests_run++; if (d !== {8'h0, r[15:8]}) begin tests_failed++; $display("FAIL gpio_in1 got=%h exp=%h", d, {8'h0, r[15:8]}); end
        gpio_i = '0;
        tick(4);
        wr(15'h6007, 16'h00FF);
        wr(15'h600B, 16'h00FF);
        tick(2);
    endtask

    task automatic test_edge_flags;
        logic [15:0] d;
        logic [7:0] m, clr;
        peek(15'h6007, d);
        tests_run++; if (d !== 16'h0 || irq !== 1'b0) begin tests_failed++; $display("FAIL edge_idle got=%h/%b exp=0000/0", d, irq); end
        gpio_i[3] = 1'b1;
        tick(2);
        peek(15'h6007, d);
        tests_run++; if (d !== 16'h0000) begin tests_failed++; $display("FAIL edge_too_early got=%h exp=0000", d); end
        tick(1);
        peek(15'h6007, d);
        tests_run++; if (d !== 16'h0008 || irq !== 1'b0) begin tests_failed++; $display("FAIL edge_set got=%h/%b exp=0008/0", d, irq); end
        tick(1);
        tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL edge_irq got=%b exp=1", irq); end
        wr(15'h6007, 16'h0008);
        peek(15'h6007, d);
        tests_run++; if (d !== 16'h0000) begin tests_failed++; $display("FAIL edge_clear got=%h exp=0000", d); end
        tick(1);
        tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL edge_irq_clear got=%b exp=0", irq); end
        gpio_i[3] = 1'b0;
        tick(3);
        gpio_i[3] = 1'b1;
        tick(2);
        wr(15'h6007, 16'h0008);
        peek(15'h6007, d);
        tests_run++; if (d !== 16'h0008) begin tests_failed++; $display("FAIL edge_set_wins got=%h exp=0008", d); end
        wr(15'h6007, 16'h0008);
        m = 8'($urandom_range(1, 255));
        gpio_i[15:8] = m;
        tick(3);
        peek(15'h600B, d);
        tests_run++; if (d !== {8'h0, m}) begin tests_failed++; $display("FAIL edge_rand_set got=%h exp=%h", d, {8'h0, m}); end
        clr = 8'($urandom);
        wr(15'h600B, {8'hFF, clr});
        peek(15'h600B, d);
        tests_run++; if (d !== {8'h0, m & ~clr}) begin tests_failed++; $display("FAIL edge_rand_clear got=%h exp=%h", d, {8'h0, m & ~clr}); end
        wr(15'h600B, 16'h00FF);
        wr(15'h6007, 16'h00FF);
        tick(2);
    endtask

    task automatic test_fifo_order;
        logic [15:0] d;
        logic [7:0] code;
        bit [255:0] seen;
        seen = '0;
        kq.delete();
        for (int i = 0; i < 9; i++) begin
            do code = 8'($urandom_range(1, 255)); while (seen[code]);
            seen[code] = 1'b1;
            if (kq.size() < 8) kq.push_back(code);
            press(code);
        end
        tick(2);
        peek(15'h6002, d);
        tests_run++; if (d !== 16'h8008) begin tests_failed++; $display("FAIL fifo_kstat_full got=%h exp=8008", d); end
        tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL fifo_irq got=%b exp=1", irq); end
        for (int i = 0; i < 8; i++) begin
            pop(d);
            tests_run++; if (d !== {8'h0, kq[i]}) begin tests_failed++; $display("FAIL fifo_order[%0d] got=%h exp=%h", i, d, {8'h0, kq[i]}); end
        end
        pop(d);
        tests_run++; if (d !== 16'h0) begin tests_failed++; $display("FAIL fifo_empty_pop got=%h exp=0000", d); end
        peek(15'h6002, d);
        tests_run++; if (d !== 16'h8000) begin tests_failed++; $display("FAIL fifo_kstat_drained got=%h exp=8000", d); end
        wr(15'h6002, 16'h8000);
        peek(15'h6002, d);
        tests_run++; if (d !== 16'h0) begin tests_failed++; $display("FAIL fifo_ovf_clear got=%h exp=0000", d); end
        kq.delete();
    endtask

    task automatic test_held_key;
        logic [15:0] d;
        keycode = 8'h20;
        tick(3);
        for (int i = 0; i < 97; i++) begin
            if (i % 16 == 0) begin
                peek(15'h6000, d);
                tests_run++; if (d !== 16'h0020) begin tests_failed++; $display("FAIL held_kbd[%0d] got=%h exp=0020", i, d); end
            end
            tick(1);
        end
        peek(15'h6002, d);
        tests_run++; if (d !== 16'h0001) begin tests_failed++; $display("FAIL held_count got=%h exp=0001", d); end
        keycode = 8'h00;
        pop(d);
        tests_run++; if (d !== 16'h0020) begin tests_failed++; $display("FAIL held_pop got=%h exp=0020", d); end
        tick(3);
    endtask

    task automatic test_back_to_back;
        logic [15:0] d;
        logic [7:0] code, newest;
        kq.delete();
        for (int i = 0; i < 8; i++) begin
            code = 8'($urandom_range(1, 255));
            kq.push_back(code);
            press(code);
        end
        tick(1);
        peek(15'h6002, d);
        tests_run++; if (d !== 16'h0008) begin tests_failed++; $display("FAIL b2b_full got=%h exp=0008", d); end
        newest = 8'($urandom_range(1, 255));
        keycode = newest;
        tick(2);
        pop(d);
        tests_run++; if (d !== {8'h0, kq[0]}) begin tests_failed++; $display("FAIL b2b_head got=%h exp=%h", d, {8'h0, kq[0]}); end
        void'(kq.pop_front());
        kq.push_back(newest);
        peek(15'h6002, d);
        tests_run++; if (d !== 16'h0008) begin tests_failed++; $display("FAIL b2b_kstat got=%h exp=0008", d); end
        keycode = 8'h00;
        for (int i = 0; i < 8; i++) begin
            pop(d);
            tests_run++; if (d !== {8'h0, kq[i]}) begin tests_failed++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, d, {8'h0, kq[i]}); end
        end
        kq.delete();
    endtask

    task automatic test_reset_mid;
        logic [15:0] d;
        press(8'h5A);
        press(8'h3C);
        wr(15'h6005, 16'h0077);
        wr(15'h6006, 16'h0011);
        gpio_i[0] = 1'b1;
        tick(3);
        peek(15'h6007, d);
        tests_run++; if (d !== 16'h0001) begin tests_failed++; $display("FAIL mid_edge_pre got=%h exp=0001", d); end
        reset_n = 1'b0;
        tick(1);
        tests_run++; if (gpio_o !== 16'h0 || gpio_oe !== 16'h0 || irq !== 1'b0) begin
            tests_failed++; $display("FAIL mid_reset_pins got=%h/%h/%b exp=0000/0000/0", gpio_o, gpio_oe, irq);
        end
        peek(15'h6002, d);
        tests_run++; if (d !== 16'h0) begin tests_failed++; $display("FAIL mid_reset_kstat got=%h exp=0000", d); end
        peek(15'h6007, d);
        tests_run++; if (d !== 16'h0) begin tests_failed++; $display("FAIL mid_reset_edge got=%h exp=0000", d); end
        reset_n = 1'b1;
        gpio_i = '0;
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.bus_strobe = 1'b0;
        bus_if.bus_write = 1'b0;
        bus_if.bus_address = '0;
        bus_if.bus_wdata = '0;
        test_reset;
        test_hit;
        test_gpio_write;
        test_edge_flags;
        test_fifo_order;
        test_held_key;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/hack_mmio_peripherals.md
# hack_mmio_peripherals

Parametrised memory-mapped peripheral block for the Hack SoC. It replaces the fixed keyboard / 4-bit GPIO_I / 4-bit GPIO_O decode with:
- a window of registers at a configurable base address;
- N GPIO channels of configurable width, each with direction control, input synchronisers and sticky rising-edge flags;
- a keycode FIFO so key presses between CPU polls are not lost.

It sits beside the RAM/VRAM encoders and is driven by the same per-Hack-cycle write/read strobe.

## Interface
- WORD_WIDTH, 16, data word width
- ADDRESS_WIDTH, 15, Hack data address width
- BASE_ADDRESS, 'h6000, address of register offset 0
- GPIO_CHANNELS, 2, number of GPIO channels (1..8)
- GPIO_WIDTH, 8, bits per channel (1..WORD_WIDTH)
- KEY_FIFO_DEPTH, 8, keycode FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- bus_strobe  in  1  one-clk pulse per Hack cycle that commits a write or a read side effect
- bus_address  in  ADDRESS_WIDTH  Hack addressM
- bus_write  in  1  Hack writeM
- bus_wdata  in  WORD_WIDTH  Hack outM
- bus_rdata  out  WORD_WIDTH  combinational read data for bus_address; 0 when not hit
- bus_hit  out  1  bus_address lies in [BASE_ADDRESS, BASE_ADDRESS+4+4*GPIO_CHANNELS)
- keycode  in  8  asynchronous keyboard level, 0 = no key
- gpio_i  in  GPIO_CHANNELS*GPIO_WIDTH  asynchronous pin inputs
- gpio_o  out  GPIO_CHANNELS*GPIO_WIDTH  output register
- gpio_oe  out  GPIO_CHANNELS*GPIO_WIDTH  1 = pin driven
- irq  out  1  registered; OR of all edge flags, or FIFO non-empty

## Operation
Register map (offsets from BASE_ADDRESS); writes take effect only when bus_strobe and bus_write are both high.
- 0 KBD: synchronised current keycode, zero-extended (legacy-compatible level). Read-only.
- 1 KFIFO: read returns the head entry (0 if empty). A read commit (bus_strobe && !bus_write) pops one entry if not empty. Writes are ignored.
- 2 KSTAT: bit15 overflow, bits[$clog2(KEY_FIFO_DEPTH):0] count. Writing bit15=1 clears overflow.
- 3: reads 0. Writes are ignored.
- 4+4c GPIO_IN(c): synchronised pins of channel c. Read-only.
- 5+4c GPIO_OUT(c): read/write, low GPIO_WIDTH bits.
- 6+4c GPIO_DIR(c): read/write, 1 = output. Drives gpio_oe.
- 7+4c GPIO_EDGE(c): sticky rising-edge flags. Writing 1 to a bit clears that bit.
- Unused upper bits read 0. Channel c occupies bits [c*GPIO_WIDTH +: GPIO_WIDTH] of gpio_i, gpio_o and gpio_oe.

Keyboard path:
- keycode passes through a 2-flop synchroniser (ksync), then a previous-value register (kprev).
- Push ksync when ksync != 0 and ksync != kprev. A held key therefore pushes exactly once.
- FIFO full with push and no pop: entry dropped, overflow set.
- Full with push and pop in the same cycle: both occur, count unchanged, no overflow.
- Empty with pop: no change.
- Pointers wrap modulo KEY_FIFO_DEPTH. count ranges 0..KEY_FIFO_DEPTH.

GPIO input path:
- 2-flop synchroniser (gsync), then a previous-value register (gprev).
- An edge flag bit sets when gsync & ~gprev.
- Set and write-1-clear in the same cycle: set wins.

Reset values, all applied while reset_n = 0 at a clk edge:
- gpio_o, gpio_oe, edge flags, synchronisers, kprev: 0
- FIFO pointers, count and overflow: 0
- irq: 0
- bus_rdata: reads 0 for FIFO/status; it stays combinational.

## Timing
- bus_rdata and bus_hit are combinational from bus_address and register state, with no added latency.
- Register writes, FIFO pops and flag clears commit at the clk edge where bus_strobe = 1. They are visible on outputs and reads from the next cycle.
- gpio_o and gpio_oe change 1 clk after the write-commit edge.
- Pin rising edge to edge flag set: 3 clk (2 sync + 1 edge register). irq rises 1 clk after that.
- keycode change to FIFO push: 3 clk. count and KFIFO read reflect it on the following cycle.
- bus_strobe with an address outside the window has no effect.
- reset_n low mid-operation clears all state at the next clk edge, including a FIFO holding entries; pending edges are lost.

## Test plan
- Reset: hold reset_n=0 for 2 clk with gpio_i toggling and keycode='h41 -> gpio_o=0, gpio_oe=0, irq=0, KSTAT reads 0 after release until a push occurs.
- GPIO write/dir: write 'h00A5 to GPIO_OUT(1) ('h6009) and 'h00FF to GPIO_DIR(1) ('h600A) -> gpio_o[15:8]='hA5, gpio_oe[15:8]='hFF one clk after each commit; channel 0 unchanged.
- Edge flags: raise gpio_i[3] -> GPIO_EDGE(0) ('h6007) reads 'h0008 3 clk later, irq=1. Write 'h0008 -> reads 0 and irq=0. Retoggle gpio_i[3] in the clear cycle -> flag remains 1.
- FIFO order/overflow (depth 8): apply 9 distinct keycodes, each held 4 clk with 0 between -> KSTAT='h8008. Popping 8 times from 'h6001 returns the first 8 codes in order, then 0. Write 'h8000 to KSTAT -> reads 0.
- Held key: keycode='h20 for 100 clk -> exactly one push. KBD reads 'h0020 throughout.
- Full push+pop in the same cycle: FIFO full, new key arrives in the same cycle as a pop commit -> count stays 8, overflow 0, newest entry is the tail.
